conv3x3_relu: RTL and testbench
===============================

Name: conv3x3_relu

Overview:
- Streaming-free, RAM-to-RAM 3x3 valid convolution with bias, arithmetic shift, ReLU and saturation.
- Sits directly upstream of the 2x2 max-pooling engine. It reads an H_in x W_in feature map from the input data RAM and writes an (H_in-2) x (W_in-2) map into the RAM the pooling stage reads as its data RAM.
- Uses the same start/intr handshake as the pooling engine, so a top level can chain start(pool) = intr(conv).

Parameters:
- H_in, 12, input map height (>=3)
- W_in, 12, input map width (>=3)
- DATA_W, 8, signed two's-complement width of pixels, weights and bias
- SHIFT, 4, arithmetic right shift applied to the accumulator before ReLU
- ADDR_W, 8, address width of the ifm and ofm ports; must cover H_in*W_in

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until intr
- intr  out  1  one-cycle done pulse
- ifm_rd  out  1  input RAM read enable
- ifm_addr  out  ADDR_W  input RAM address, row-major
- ifm_rdata  in  DATA_W  input RAM data; valid the cycle after ifm_rd (synchronous read)
- wgt_rd  out  1  weight RAM read enable
- wgt_addr  out  4  weight RAM address
- wgt_rdata  in  DATA_W  weight data; 1-cycle read latency
- ofm_we  out  1  output RAM write enable
- ofm_addr  out  ADDR_W  output RAM address, row-major
- ofm_wdata  out  DATA_W  output pixel

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0.
- Reset asserted mid-operation aborts at once. No further ofm_we and no intr are produced.
- Derived sizes: H_out = H_in-2, W_out = W_in-2, N = H_out*W_out.
- FSM states: IDLE -> LOAD_W -> MAC -> WRITE -> (MAC | DONE) -> IDLE.
- IDLE:
  - start=1 moves to LOAD_W.
  - start while not in IDLE is ignored; it is not queued.
- LOAD_W: 11 cycles.
  - Issues wgt_rd on addresses 0..9 in consecutive cycles.
  - Address k (0..8) is kernel weight w[kr][kc], k = kr*3+kc. Address 9 is the bias.
  - Data is captured into internal registers one cycle after each read.
- MAC: 10 cycles per output pixel (r,c).
  - Cycles 0..8 issue ifm_rd with ifm_addr = (r+kr)*W_in + (c+kc), k in row-major kernel order.
  - Cycles 1..9 accumulate acc += w[k]*x (signed).
  - acc is seeded with the sign-extended bias.
  - Accumulator width is 2*DATA_W+4; it never overflows.
- WRITE: 1 cycle, ofm_we=1, ofm_addr = r*W_out + c.
  - ofm_wdata = 0 if acc<0.
  - Otherwise ofm_wdata = min(acc >>> SHIFT, 2^(DATA_W-1)-1).
  - The result is always non-negative.
  - Then c increments; it wraps to 0 with r+1 at W_out.
  - After pixel N-1 the FSM goes to DONE, otherwise back to MAC.
- DONE: intr=1 for exactly one cycle, busy drops in the same cycle, then IDLE.
- Timing, with start high in cycle 0:
  - ofm_we for pixel p in cycle 22+11p.
  - intr in cycle 11N+12. Defaults: N=100, intr in cycle 1112.
- Read/write enables are high only in their stated cycles.
- Address outputs hold their last value otherwise.
- ofm_wdata holds its last value otherwise.
- A new start in the cycle after intr is accepted and reloads the weights.

Test Plan:
- Weights all 0, bias 5, SHIFT=0, arbitrary input -> all 100 outputs = 5; intr exactly in cycle 1112, single pulse.
- Centre weight 1, others 0, bias 0, SHIFT=0, input[i]=i mod 100 -> out[r*10+c] = input[(r+1)*12+c+1].
- All weights -1, input all 10, bias 0 -> every output 0 (ReLU clamp).
- All weights 127, input all 127, bias 127, SHIFT=4 -> every output 127 (saturation).
- Start pulsed again at cycle 300 while busy -> ignored; output identical to single run; exactly one intr.
- Reset asserted at cycle 500, then released and restarted -> no ofm_we after reset; the fresh run matches the expected map and intr timing relative to the new start.

Source files
------------

// File: rtl/conv3x3_relu.sv
// RAM-to-RAM 3x3 valid convolution with bias, arithmetic shift, ReLU and saturation.
// Loads 9 weights plus a bias, then computes one output pixel per 11 cycles (10 MAC + 1 WRITE).
module conv3x3_relu #(
    parameter int unsigned H_IN   = 12,
    parameter int unsigned W_IN   = 12,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SHIFT  = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              intr,
    output logic              ifm_rd,
    output logic [ADDR_W-1:0] ifm_addr,
    input  logic [DATA_W-1:0] ifm_rdata,
    output logic              wgt_rd,
    output logic [3:0]        wgt_addr,
    input  logic [DATA_W-1:0] wgt_rdata,
    output logic              ofm_we,
    output logic [ADDR_W-1:0] ofm_addr,
    output logic [DATA_W-1:0] ofm_wdata
);

    localparam int unsigned H_OUT  = H_IN - 2;
    localparam int unsigned W_OUT  = W_IN - 2;
    localparam int unsigned ACC_W  = 2 * DATA_W + 4;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = 4;
    localparam logic [ACC_W-1:0] MAX_POS = ACC_W'((1 << (DATA_W - 1)) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]         r_row, w_row_nxt;
    logic [ADDR_W-1:0]         r_col, w_col_nxt;
    logic signed [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic signed [DATA_W-1:0]  r_wgt [0:9];

    logic                      r_busy, w_busy_nxt;
    logic                      r_intr, w_intr_nxt;
    logic                      r_ifm_rd, w_ifm_rd_nxt;
    logic [ADDR_W-1:0]         r_ifm_addr, w_ifm_addr_nxt;
    logic                      r_wgt_rd, w_wgt_rd_nxt;
    logic [3:0]                r_wgt_addr, w_wgt_addr_nxt;
    logic                      r_ofm_we, w_ofm_we_nxt;
    logic [ADDR_W-1:0]         r_ofm_addr, w_ofm_addr_nxt;
    logic [DATA_W-1:0]         r_ofm_wdata, w_ofm_wdata_nxt;

    logic [CNT_W-1:0]          w_kidx;
    logic signed [DATA_W-1:0]  w_wsel;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_bias_ext;
    logic signed [ACC_W-1:0]   w_shift;
    logic [DATA_W-1:0]         w_relu;
    logic [ADDR_W-1:0]         w_kr;
    logic [ADDR_W-1:0]         w_kc;
    logic                      w_last_col;
    logic                      w_last_pix;

    // MAC cycle k (1..9) multiplies weight k-1 by the pixel read in cycle k-1
    assign w_kidx     = r_cnt - CNT_W'(1);
    assign w_wsel     = (w_kidx < CNT_W'(9)) ? r_wgt[w_kidx] : '0;
    assign w_prod     = PROD_W'(w_wsel) * PROD_W'($signed(ifm_rdata));
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_bias_ext = ACC_W'(r_wgt[9]);
    assign w_last_col = (r_col == ADDR_W'(W_OUT - 1));
    assign w_last_pix = w_last_col && (r_row == ADDR_W'(H_OUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_acc_nxt   = r_acc;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD_W;
                    w_cnt_nxt   = '0;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            S_LOAD_W: begin
                if (r_cnt == CNT_W'(10)) begin
                    w_state_nxt = S_MAC;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_MAC: begin
                w_acc_nxt = (r_cnt == '0) ? w_bias_ext : (r_acc + w_prod_ext);
                if (r_cnt == CNT_W'(9)) begin
                    w_state_nxt = S_WRITE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WRITE: begin
                w_state_nxt = w_last_pix ? S_DONE : S_MAC;
                w_cnt_nxt   = '0;
                if (w_last_col) begin
                    w_col_nxt = '0;
                    w_row_nxt = r_row + ADDR_W'(1);
                end else begin
                    w_col_nxt = r_col + ADDR_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Kernel row/column of the read issued in the upcoming MAC cycle
    always_comb begin
        w_kr = '0;
        case (w_cnt_nxt)
            4'd0, 4'd1, 4'd2: w_kr = ADDR_W'(0);
            4'd3, 4'd4, 4'd5: w_kr = ADDR_W'(1);
            default:          w_kr = ADDR_W'(2);
        endcase
        w_kc = ADDR_W'(w_cnt_nxt) - ADDR_W'(3) * w_kr;
    end

    // ReLU then saturate to the largest positive pixel value
    always_comb begin
        w_shift = w_acc_nxt >>> SHIFT;
        if (w_acc_nxt[ACC_W-1])
            w_relu = '0;
        else if (w_shift > MAX_POS)
            w_relu = DATA_W'(MAX_POS);
        else
            w_relu = DATA_W'(w_shift);
    end

    // Registered outputs derived from the state being entered
    always_comb begin
        w_busy_nxt      = (w_state_nxt == S_LOAD_W) || (w_state_nxt == S_MAC) ||
                          (w_state_nxt == S_WRITE);
        w_intr_nxt      = (w_state_nxt == S_DONE);
        w_wgt_rd_nxt    = (w_state_nxt == S_LOAD_W) && (w_cnt_nxt <= CNT_W'(9));
        w_wgt_addr_nxt  = w_wgt_rd_nxt ? w_cnt_nxt : r_wgt_addr;
        w_ifm_rd_nxt    = (w_state_nxt == S_MAC) && (w_cnt_nxt <= CNT_W'(8));
        w_ifm_addr_nxt  = w_ifm_rd_nxt ?
                          ((w_row_nxt + w_kr) * ADDR_W'(W_IN) + w_col_nxt + w_kc) : r_ifm_addr;
        w_ofm_we_nxt    = (w_state_nxt == S_WRITE);
        w_ofm_addr_nxt  = w_ofm_we_nxt ? (r_row * ADDR_W'(W_OUT) + r_col) : r_ofm_addr;
        w_ofm_wdata_nxt = w_ofm_we_nxt ? w_relu : r_ofm_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_acc       <= '0;
            r_busy      <= 1'b0;
            r_intr      <= 1'b0;
            r_ifm_rd    <= 1'b0;
            r_ifm_addr  <= '0;
            r_wgt_rd    <= 1'b0;
            r_wgt_addr  <= '0;
            r_ofm_we    <= 1'b0;
            r_ofm_addr  <= '0;
            r_ofm_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_acc       <= w_acc_nxt;
            r_busy      <= w_busy_nxt;
            r_intr      <= w_intr_nxt;
            r_ifm_rd    <= w_ifm_rd_nxt;
            r_ifm_addr  <= w_ifm_addr_nxt;
            r_wgt_rd    <= w_wgt_rd_nxt;
            r_wgt_addr  <= w_wgt_addr_nxt;
            r_ofm_we    <= w_ofm_we_nxt;
            r_ofm_addr  <= w_ofm_addr_nxt;
            r_ofm_wdata <= w_ofm_wdata_nxt;
        end
    end

    // Weight read for address k returns during LOAD_W count k+1; slot 9 is the bias
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) r_wgt[i] <= '0;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if ((r_state == S_LOAD_W) && (r_cnt == CNT_W'(i + 1)))
                    r_wgt[i] <= $signed(wgt_rdata);
            end
        end
    end

    assign busy      = r_busy;
    assign intr      = r_intr;
    assign ifm_rd    = r_ifm_rd;
    assign ifm_addr  = r_ifm_addr;
    assign wgt_rd    = r_wgt_rd;
    assign wgt_addr  = r_wgt_addr;
    assign ofm_we    = r_ofm_we;
    assign ofm_addr  = r_ofm_addr;
    assign ofm_wdata = r_ofm_wdata;

endmodule

// File: tb/tb_conv3x3_relu.sv
// Directed bench for conv3x3_relu: two instances (SHIFT=0 and SHIFT=4) share RAM contents.
module tb_conv3x3_relu;

    localparam int NPIX = 100;

    logic clk = 1'b0;
    logic rst;
    logic start;

    logic       busy_a, intr_a, ifm_rd_a, wgt_rd_a, ofm_we_a;
    logic [7:0] ifm_addr_a, ofm_addr_a, ofm_wdata_a;
    logic [3:0] wgt_addr_a;
    logic [7:0] ifm_rdata_a = '0, wgt_rdata_a = '0;

    logic       busy_b, intr_b, ifm_rd_b, wgt_rd_b, ofm_we_b;
    logic [7:0] ifm_addr_b, ofm_addr_b, ofm_wdata_b;
    logic [3:0] wgt_addr_b;
    logic [7:0] ifm_rdata_b = '0, wgt_rdata_b = '0;

    logic signed [7:0] ifm_mem [0:143];
    logic signed [7:0] wgt_mem [0:9];

    typedef struct {
        string name;
        int    w_all;
        int    w_ctr;
        int    bias;
        int    in_mode;   // -1 random, -2 index mod 100, otherwise constant pixel
        bit    centre;    // expected = centre pixel >>> shift
        int    exp0;
        int    exp4;
    } vec_t;

    vec_t vecs [7];

    int cyc = 0;
    int t0 = 0;
    int nchk = 0;
    int nerr = 0;
    int val_a [0:NPIX-1];
    int val_b [0:NPIX-1];
    int tim_a [0:NPIX-1];
    int tim_b [0:NPIX-1];
    int we_a, we_b, in_a, in_b, it_a, it_b, intr_busy;

    conv3x3_relu #(.H_IN(12), .W_IN(12), .DATA_W(8), .SHIFT(0), .ADDR_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .intr(intr_a),
        .ifm_rd(ifm_rd_a), .ifm_addr(ifm_addr_a), .ifm_rdata(ifm_rdata_a),
        .wgt_rd(wgt_rd_a), .wgt_addr(wgt_addr_a), .wgt_rdata(wgt_rdata_a),
        .ofm_we(ofm_we_a), .ofm_addr(ofm_addr_a), .ofm_wdata(ofm_wdata_a)
    );

    conv3x3_relu #(.H_IN(12), .W_IN(12), .DATA_W(8), .SHIFT(4), .ADDR_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .intr(intr_b),
        .ifm_rd(ifm_rd_b), .ifm_addr(ifm_addr_b), .ifm_rdata(ifm_rdata_b),
        .wgt_rd(wgt_rd_b), .wgt_addr(wgt_addr_b), .wgt_rdata(wgt_rdata_b),
        .ofm_we(ofm_we_b), .ofm_addr(ofm_addr_b), .ofm_wdata(ofm_wdata_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifm_rd_a) ifm_rdata_a <= ifm_mem[ifm_addr_a];
        if (ifm_rd_b) ifm_rdata_b <= ifm_mem[ifm_addr_b];
        if (wgt_rd_a) wgt_rdata_a <= wgt_mem[wgt_addr_a];
        if (wgt_rd_b) wgt_rdata_b <= wgt_mem[wgt_addr_b];
    end

    // Output RAM models plus event timing relative to the start cycle
    always @(negedge clk) begin
        if (ofm_we_a) begin
            we_a = we_a + 1;
            if (int'(ofm_addr_a) < NPIX) begin
                val_a[ofm_addr_a] = int'(ofm_wdata_a);
                tim_a[ofm_addr_a] = cyc - t0;
            end
        end
        if (ofm_we_b) begin
            we_b = we_b + 1;
            if (int'(ofm_addr_b) < NPIX) begin
                val_b[ofm_addr_b] = int'(ofm_wdata_b);
                tim_b[ofm_addr_b] = cyc - t0;
            end
        end
        if (intr_a) begin in_a = in_a + 1; it_a = cyc - t0; end
        if (intr_b) begin in_b = in_b + 1; it_b = cyc - t0; end
        if ((intr_a && busy_a) || (intr_b && busy_b)) intr_busy = intr_busy + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        nchk = nchk + 1;
        if (act != exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        for (int p = 0; p < NPIX; p++) begin
            val_a[p] = -999; val_b[p] = -999; tim_a[p] = -1; tim_b[p] = -1;
        end
        we_a = 0; we_b = 0; in_a = 0; in_b = 0; it_a = -1; it_b = -1; intr_busy = 0;
    endtask

    task automatic run_case(input int idx, input int restart_at, input int reset_at);
        vec_t v;
        int   bad_a, bad_b, e0, e4, px;
        v = vecs[idx];
        for (int k = 0; k < 9; k++) wgt_mem[k] = 8'((k == 4) ? v.w_ctr : v.w_all);
        wgt_mem[9] = 8'(v.bias);
        for (int i = 0; i < 144; i++) begin
            if (v.in_mode == -1)      ifm_mem[i] = 8'($urandom);
            else if (v.in_mode == -2) ifm_mem[i] = 8'(i % 100);
            else                      ifm_mem[i] = 8'(v.in_mode);
        end
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({v.name, " busy_cycle1"}, int'(busy_a) + int'(busy_b), 2);

        if (reset_at > 0) begin
            while (cyc - t0 < reset_at) @(negedge clk);
            rst = 1'b1;
            #1;
            clear_mon();
            chk("reset_mid_outputs", int'(busy_a) + int'(ofm_we_a) + int'(ifm_rd_a) +
                int'(busy_b) + int'(ofm_we_b) + int'(ifm_rd_b), 0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (60) @(negedge clk);
            chk("reset_no_we", we_a + we_b, 0);
            chk("reset_no_intr", in_a + in_b, 0);
            chk("reset_busy_low", int'(busy_a) + int'(busy_b), 0);
            return;
        end

        while ((in_a == 0 || in_b == 0) && (cyc - t0 < 2000)) begin
            @(negedge clk);
            start = (restart_at > 0 && (cyc - t0) == restart_at) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        repeat (5) @(negedge clk);

        chk({v.name, " intr_count_a"}, in_a, 1);
        chk({v.name, " intr_count_b"}, in_b, 1);
        chk({v.name, " intr_cycle_a"}, it_a, 1112);
        chk({v.name, " intr_cycle_b"}, it_b, 1112);
        chk({v.name, " we_count_a"}, we_a, NPIX);
        chk({v.name, " we_count_b"}, we_b, NPIX);
        chk({v.name, " busy_at_intr"}, intr_busy, 0);
        chk({v.name, " busy_after"}, int'(busy_a) + int'(busy_b), 0);

        bad_a = 0;
        bad_b = 0;
        for (int p = 0; p < NPIX; p++) begin
            if (v.centre) begin
                px = int'(ifm_mem[((p / 10) + 1) * 12 + (p % 10) + 1]);
                e0 = px;
                e4 = px >>> 4;
            end else begin
                e0 = v.exp0;
                e4 = v.exp4;
            end
            chk($sformatf("%s pix_a[%0d]", v.name, p), val_a[p], e0);
            chk($sformatf("%s pix_b[%0d]", v.name, p), val_b[p], e4);
            if (tim_a[p] != 22 + 11 * p) bad_a = bad_a + 1;
            if (tim_b[p] != 22 + 11 * p) bad_b = bad_b + 1;
        end
        chk({v.name, " we_timing_a_bad"}, bad_a, 0);
        chk({v.name, " we_timing_b_bad"}, bad_b, 0);
    endtask

    initial begin
        vecs[0] = '{"bias_only",    0,   0,   5,  -1, 1'b0,   5,   0};
        vecs[1] = '{"centre",       0,   1,   0,  -2, 1'b1,   0,   0};
        vecs[2] = '{"relu_clamp",  -1,  -1,   0,  10, 1'b0,   0,   0};
        vecs[3] = '{"saturate",   127, 127, 127, 127, 1'b0, 127, 127};
        vecs[4] = '{"mixed",        2,  -1,  -4,   3, 1'b0,  41,   2};
        vecs[5] = '{"acc_minus1",   1,   1, -10,   1, 1'b0,   0,   0};
        vecs[6] = '{"edge_128",     0,   1,   1, 127, 1'b0, 127,   8};

        rst = 1'b1;
        start = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk("rst_busy",      int'(busy_a) + int'(busy_b), 0);
        chk("rst_intr",      int'(intr_a) + int'(intr_b), 0);
        chk("rst_ifm_rd",    int'(ifm_rd_a) + int'(ifm_rd_b), 0);
        chk("rst_wgt_rd",    int'(wgt_rd_a) + int'(wgt_rd_b), 0);
        chk("rst_ofm_we",    int'(ofm_we_a) + int'(ofm_we_b), 0);
        chk("rst_ifm_addr",  int'(ifm_addr_a) + int'(ifm_addr_b), 0);
        chk("rst_wgt_addr",  int'(wgt_addr_a) + int'(wgt_addr_b), 0);
        chk("rst_ofm_addr",  int'(ofm_addr_a) + int'(ofm_addr_b), 0);
        chk("rst_ofm_wdata", int'(ofm_wdata_a) + int'(ofm_wdata_b), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy_a) + int'(busy_b), 0);

        for (int i = 0; i < 7; i++) run_case(i, 0, 0);

        run_case(1, 300, 0);
        run_case(1, 0, 500);
        run_case(1, 0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
